// File: rtl/mem_port_arbiter.sv
// Arbitrates the single MIPS32 memory port between instruction fetch and load/store,
// with bus timeout and pipeline stall. Define MEM_ARB_RR_EN for a round-robin tie-break.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_ack,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_be,
   output logic [DW-1:0]   d_rdata,
   output logic            d_ack,
   output logic            bus_err,
   output logic            m_req,
   output logic            m_we,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_be,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ready,
   output logic            stall
);

   localparam int BW = DW / 8;
   localparam int CW = 8;

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_m_req;
   logic            r_m_we;
   logic [AW-1:0]   r_m_addr;
   logic [DW-1:0]   r_m_wdata;
   logic [BW-1:0]   r_m_be;
   logic [DW-1:0]   r_if_rdata;
   logic [DW-1:0]   r_d_rdata;
   logic            r_if_ack;
   logic            r_d_ack;
   logic            r_bus_err;

   logic            w_pick_d;
   logic            w_timeout;

`ifdef MEM_ARB_RR_EN
   logic            r_last_grant;   // 0 = IF granted last, 1 = D granted last

   // NOTE: always_comb assigns its output on every path so no latch is inferred.
   always_comb begin
      w_pick_d = d_req & (~if_req | ~r_last_grant);
   end
`else
   always_comb begin
      w_pick_d = d_req;
   end
`endif

   // The count reaches TIMEOUT on the edge that ends the TIMEOUT-th waiting cycle.
   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_m_req    <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_m_be     <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_if_ack   <= 1'b0;
         r_d_ack    <= 1'b0;
         r_bus_err  <= 1'b0;
`ifdef MEM_ARB_RR_EN
         r_last_grant <= 1'b0;
`endif
      end else begin
         r_if_ack  <= 1'b0;
         r_d_ack   <= 1'b0;
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_d) begin
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_wdata;
                  r_m_be    <= d_be;
                  r_m_req   <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= GNT_D;
`ifdef MEM_ARB_RR_EN
                  r_last_grant <= 1'b1;
`endif
               end else if (if_req) begin
                  r_m_we    <= 1'b0;
                  r_m_addr  <= if_addr;
                  r_m_wdata <= '0;
                  r_m_be    <= '1;
                  r_m_req   <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= GNT_IF;
`ifdef MEM_ARB_RR_EN
                  r_last_grant <= 1'b0;
`endif
               end
            end
            GNT_IF, GNT_D: begin
               if (m_ready) begin
                  r_m_req <= 1'b0;
                  r_state <= DONE;
                  if (r_state == GNT_IF) begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= m_rdata;
                  end else begin
                     r_d_ack <= 1'b1;
                     if (!r_m_we) begin
                        r_d_rdata <= m_rdata;
                     end
                  end
               end else if (w_timeout) begin
                  r_m_req   <= 1'b0;
                  r_state   <= DONE;
                  r_bus_err <= 1'b1;
                  r_cnt     <= r_cnt + 1'b1;
                  if (r_state == GNT_IF) begin
                     r_if_ack <= 1'b1;
                  end else begin
                     r_d_ack <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_req    = r_m_req;
   assign m_we     = r_m_we;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign m_be     = r_m_be;
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;
   assign if_ack   = r_if_ack;
   assign d_ack    = r_d_ack;
   assign bus_err  = r_bus_err;

   assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (default build): directed accesses, contention,
// timeout, timeout/ready tie and mid-access reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_err;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata;
   logic        m_ready;
   logic        stall;

   typedef struct {
      bit          is_d;
      bit          err;
      logic [31:0] if_rd;
      logic [31:0] d_rd;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_d_rdata  = '0;
   int          n_mreq;
   int          n_cyc;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_be     (d_be),
      .d_rdata  (d_rdata),
      .d_ack    (d_ack),
      .bus_err  (bus_err),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_be     (m_be),
      .m_rdata  (m_rdata),
      .m_ready  (m_ready),
      .stall    (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_exp(input bit is_d, input bit err);
      exp_t e;
      e.is_d  = is_d;
      e.err   = err;
      e.if_rd = exp_if_rdata;
      e.d_rd  = exp_d_rdata;
      sb_q.push_back(e);
   endtask

   // Monitor: every ack pulse is matched against the oldest expected completion.
   always @(negedge clk) begin
      if (rst_n && (if_ack || d_ack)) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack actual if_ack=%b d_ack=%b expected none", if_ack, d_ack);
         end else begin
            mon_e = sb_q.pop_front();
            check("ack_type", {30'b0, d_ack, if_ack}, mon_e.is_d ? 32'd2 : 32'd1);
            check("bus_err", bus_err, mon_e.err);
            check("if_rdata", if_rdata, mon_e.if_rd);
            check("d_rdata", d_rdata, mon_e.d_rd);
         end
      end
   end

   // Request must already be raised; answers m_ready after wait_cyc low m_req cycles.
   task automatic run_access(input bit is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int wait_cyc, input bit give_ready, input logic [31:0] rdata,
                             output int o_mreq, output int o_cyc);
      bit got;
      bit first;
      o_mreq = 0;
      o_cyc  = 0;
      got    = 1'b0;
      first  = 1'b1;
      #1 check("stall_req", stall, 1);
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         o_cyc++;
         if (is_d ? d_ack : if_ack) begin
            check("other_ack", is_d ? if_ack : d_ack, 0);
            if (!(is_d ? if_req : d_req)) check("stall_ack", stall, 0);
            m_ready = 1'b0;
            if (is_d) d_req = 1'b0;
            else if_req = 1'b0;
            got = 1'b1;
         end else begin
            check("stall_wait", stall, 1);
            if (m_req) begin
               o_mreq++;
               if (first) begin
                  check("m_we", m_we, we);
                  check("m_addr", m_addr, addr);
                  check("m_wdata", m_wdata, wdata);
                  check("m_be", m_be, be);
                  first = 1'b0;
               end
            end
            if (give_ready && o_mreq == wait_cyc + 1) begin
               m_ready = 1'b1;
               m_rdata = rdata;
            end
         end
      end
      check("ack_seen", got, 1);
      tick();
      check("idle_mreq", m_req, 0);
      check("ack_pulse", {if_ack, d_ack, bus_err}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_be    = '0;
      m_rdata = '0;
      m_ready = 1'b0;
      tick();
      tick();
      check("rst_m_req", m_req, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wdata", m_wdata, 0);
      check("rst_m_be", m_be, 0);
      check("rst_acks", {if_ack, d_ack, bus_err}, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;
      tick();

      // m_ready while idle is ignored
      m_ready = 1'b1;
      m_rdata = 32'h5555_AAAA;
      tick();
      tick();
      check("idle_ready_mreq", m_req, 0);
      check("idle_ready_ack", {if_ack, d_ack, bus_err}, 0);
      m_ready = 1'b0;
      tick();

      // Fetch: ready one cycle after m_req, ack in cycle 3
      if_req  = 1'b1;
      if_addr = 32'h0000_0040;
      exp_if_rdata = 32'h0022_1820;
      push_exp(1'b0, 1'b0);
      run_access(1'b0, 1'b0, 32'h40, 32'h0, 4'hf, 1, 1'b1, 32'h0022_1820, n_mreq, n_cyc);
      check("fetch_latency", n_cyc, 3);
      check("fetch_if_rdata_hold", if_rdata, 32'h0022_1820);

      // Load with ready in the first m_req cycle: minimum latency
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; d_wdata = '0; d_be = 4'hf;
      exp_d_rdata = 32'hCAFE_0001;
      push_exp(1'b1, 1'b0);
      run_access(1'b1, 1'b0, 32'h2008, 32'h0, 4'hf, 0, 1'b1, 32'hCAFE_0001, n_mreq, n_cyc);
      check("load_min_latency", n_cyc, 2);

      // Store: d_rdata keeps the last load value
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      push_exp(1'b1, 1'b0);
      run_access(1'b1, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0011, 1, 1'b1, 32'h1234_5678, n_mreq, n_cyc);
      check("store_d_rdata", d_rdata, 32'hCAFE_0001);

      // Contention: D first, then IF from the IDLE after D's DONE
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_be = 4'hf;
      if_req = 1'b1; if_addr = 32'h0000_0080;
      exp_d_rdata = 32'hD00D_0002;
      push_exp(1'b1, 1'b0);
      exp_if_rdata = 32'h1111_2222;
      push_exp(1'b0, 1'b0);
      run_access(1'b1, 1'b0, 32'h2000, 32'h0, 4'hf, 0, 1'b1, 32'hD00D_0002, n_mreq, n_cyc);
      run_access(1'b0, 1'b0, 32'h80, 32'h0, 4'hf, 0, 1'b1, 32'h1111_2222, n_mreq, n_cyc);
      check("contention_if_latency", n_cyc, 2);

      // Timeout: load never answered
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = '0; d_be = 4'hf;
      m_rdata = 32'hFFFF_0000;
      push_exp(1'b1, 1'b1);
      run_access(1'b1, 1'b0, 32'h3000, 32'h0, 4'hf, 0, 1'b0, 32'h0, n_mreq, n_cyc);
      check("timeout_mreq_cycles", n_mreq, 15);
      check("timeout_ack_cycle", n_cyc, 16);

      // Tie: m_ready in the cycle the count reaches TIMEOUT
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004; d_wdata = '0; d_be = 4'hf;
      exp_d_rdata = 32'h7E57_0015;
      push_exp(1'b1, 1'b0);
      run_access(1'b1, 1'b0, 32'h3004, 32'h0, 4'hf, 14, 1'b1, 32'h7E57_0015, n_mreq, n_cyc);
      check("tie_ack_cycle", n_cyc, 16);

      // Reset mid-access in GNT_IF
      if_req = 1'b1; if_addr = 32'h0000_0100;
      tick();
      check("pre_reset_mreq", m_req, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_mreq", m_req, 0);
      check("async_reset_if_rdata", if_rdata, 0);
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
      tick();
      check("reset_no_ack", {if_ack, d_ack, bus_err}, 0);
      rst_n = 1'b1;
      exp_if_rdata = 32'h0BAD_0100;
      push_exp(1'b0, 1'b0);
      run_access(1'b0, 1'b0, 32'h100, 32'h0, 4'hf, 2, 1'b1, 32'h0BAD_0100, n_mreq, n_cyc);
      check("regrant_latency", n_cyc, 4);

      tick();
      check("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
